scs8hd_lpflow_pwrsw_seq: RTL and testbench



---
 rtl/scs8hd_lpflow_pwr_pkg.sv | 24 ++
 rtl/scs8hd_lpflow_pwr_timer.sv | 32 +++
 rtl/scs8hd_lpflow_pwrsw_seq.sv | 204 ++++++++++++++++++++
 tb/tb_scs8hd_lpflow_pwrsw_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scs8hd_lpflow_pwr_pkg.sv
// Shared definitions for the lpflow power-switch sequencer.
//   pwr_state_e  : sequencer states, from fully off through ramp, settle,
//                  power-good check, de-isolation, on, and the mirror path.
//   timer_width  : bit width needed to hold a timer load value (min 1 bit).
package scs8hd_lpflow_pwr_pkg;

    typedef enum logic [3:0] {
        OFF,
        RAMP_UP,
        SETTLE,
        CHECK,
        RESTORE,
        UNISO,
        ON,
        ISO,
        SAVE,
        RAMP_DN
    } pwr_state_e;

    function automatic int timer_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/scs8hd_lpflow_pwr_timer.sv
// Loadable saturating down-counter.
//   clk      : clock
//   reset    : synchronous active-high reset, clears the count
//   load     : load load_val this cycle (has priority over counting)
//   load_val : value to load
//   done     : count has reached zero; the counter stays at zero
// A load of N makes done assert N cycles later.
module scs8hd_lpflow_pwr_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - W'(1);
        end
    end

    assign done = (cnt_reg == '0);

endmodule

// File: rtl/scs8hd_lpflow_pwrsw_seq.sv
// Power-switch sequencer for a switchable vpwr domain (always-on side).
//   clk, reset  : clock and synchronous active-high reset
//   pwr_req     : level request, 1 = domain on
//   pwr_good    : switched-rail good, already synchronous to clk
//   fault_clr   : one-cycle pulse clearing the sticky fault
//   sw_en       : header segment enables, thermometer coded from bit 0
//   iso_en      : output isolation clamp (1 = isolated)
//   ret_en      : retention hold (1 = state held)
//   pwr_ack     : domain fully on and de-isolated
//   busy        : any transitional state
//   fault       : sticky power-good fault
//   seg_cnt     : number of enabled segments
// Segments are stepped one per STEP_CYCLES to bound rush current; after
// the last one the rail gets SETTLE_CYCLES before pwr_good is trusted and
// TIMEOUT_CYCLES (from the end of the ramp) before it is declared bad.
module scs8hd_lpflow_pwrsw_seq
    import scs8hd_lpflow_pwr_pkg::*;
#(
    parameter int NSEG           = 4,
    parameter int STEP_CYCLES    = 8,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pwr_req,
    input  logic                      pwr_good,
    input  logic                      fault_clr,
    output logic [NSEG-1:0]           sw_en,
    output logic                      iso_en,
    output logic                      ret_en,
    output logic                      pwr_ack,
    output logic                      busy,
    output logic                      fault,
    output logic [$clog2(NSEG+1)-1:0] seg_cnt
);

    localparam int CW         = $clog2(NSEG + 1);
    localparam int CHECK_SPAN = TIMEOUT_CYCLES - SETTLE_CYCLES - 1;
    localparam int SET_MAX    = (SETTLE_CYCLES - 1 > CHECK_SPAN) ? SETTLE_CYCLES - 1 : CHECK_SPAN;
    localparam int STEP_W     = timer_width(STEP_CYCLES - 1);
    localparam int SET_W      = timer_width(SET_MAX);

    localparam logic [STEP_W-1:0] STEP_LOAD   = STEP_W'(STEP_CYCLES - 1);
    localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [SET_W-1:0]  CHECK_LOAD  = SET_W'(CHECK_SPAN);
    localparam logic [CW-1:0]     SEG_FULL    = CW'(NSEG);
    localparam logic [CW-1:0]     SEG_ONE     = CW'(1);
    localparam logic [NSEG-1:0]   SW_LSB      = NSEG'(1);

    pwr_state_e        state_reg;
    logic [CW-1:0]     seg_cnt_reg;
    logic [NSEG-1:0]   sw_en_reg;
    logic              iso_en_reg;
    logic              ret_en_reg;
    logic              pwr_ack_reg;
    logic              busy_reg;
    logic              fault_reg;

    logic              step_load;
    logic              step_done;
    logic              settle_load;
    logic [SET_W-1:0]  settle_val;
    logic              settle_done;
    logic              timeout;
    logic              fault_set;
    logic              up_step;
    logic              dn_step;

    // Step timer: held preloaded outside the ramp states so the first step
    // in a new direction happens on entry and the next one STEP_CYCLES later.
    scs8hd_lpflow_pwr_timer #(.W(STEP_W)) u_step_tmr (
        .clk      (clk),
        .reset    (reset),
        .load     (step_load),
        .load_val (STEP_LOAD),
        .done     (step_done)
    );

    // Settle/timeout timer: first runs the settle window, then is reloaded
    // with the remainder of the timeout window when CHECK is entered.
    scs8hd_lpflow_pwr_timer #(.W(SET_W)) u_settle_tmr (
        .clk      (clk),
        .reset    (reset),
        .load     (settle_load),
        .load_val (settle_val),
        .done     (settle_done)
    );

    always_comb begin
        step_load   = 1'b1;
        settle_load = 1'b1;
        settle_val  = SETTLE_LOAD;
        case (state_reg)
            RAMP_UP: step_load = !pwr_req || step_done;
            RAMP_DN: step_load = (pwr_req && !fault_reg) || step_done;
            default: step_load = 1'b1;
        endcase
        case (state_reg)
            SETTLE: begin
                settle_load = settle_done;
                settle_val  = CHECK_LOAD;
            end
            CHECK:   settle_load = 1'b0;
            default: settle_load = 1'b1;
        endcase

        // Timeout outranks a simultaneous request drop so the fault is kept.
        timeout   = (state_reg == CHECK) && settle_done && !pwr_good;
        fault_set = timeout || ((state_reg == ON) && !pwr_good);

        // Segment movement decode; a step in either direction also
        // (re)enters the matching ramp state.
        up_step = ((state_reg == OFF) && pwr_req && !fault_reg)
               || ((state_reg == RAMP_UP) && pwr_req && step_done && (seg_cnt_reg != SEG_FULL))
               || ((state_reg == RAMP_DN) && pwr_req && !fault_reg);
        dn_step = ((state_reg == RAMP_UP) && !pwr_req)
               || (((state_reg == SETTLE) || (state_reg == CHECK)) && !pwr_req)
               || timeout
               || (state_reg == SAVE)
               || ((state_reg == RAMP_DN) && !(pwr_req && !fault_reg) && step_done);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= OFF;
            seg_cnt_reg <= '0;
            sw_en_reg   <= '0;
            iso_en_reg  <= 1'b1;
            ret_en_reg  <= 1'b1;
            pwr_ack_reg <= 1'b0;
            busy_reg    <= 1'b0;
            fault_reg   <= 1'b0;
        end else begin
            // A new fault event beats a clear in the same cycle.
            if (fault_set) begin
                fault_reg <= 1'b1;
            end else if (fault_clr) begin
                fault_reg <= 1'b0;
            end

            if (up_step) begin
                seg_cnt_reg <= seg_cnt_reg + SEG_ONE;
                sw_en_reg   <= (sw_en_reg << 1) | SW_LSB;
                state_reg   <= RAMP_UP;
                busy_reg    <= 1'b1;
            end else if (dn_step) begin
                seg_cnt_reg <= seg_cnt_reg - SEG_ONE;
                sw_en_reg   <= sw_en_reg >> 1;
                if (seg_cnt_reg == SEG_ONE) begin
                    state_reg <= OFF;
                    busy_reg  <= 1'b0;
                end else begin
                    state_reg <= RAMP_DN;
                    busy_reg  <= 1'b1;
                end
            end else begin
                case (state_reg)
                    // Only reached with all segments on and the last step
                    // period elapsed (or still counting).
                    RAMP_UP: if (step_done) state_reg <= SETTLE;
                    SETTLE:  if (settle_done) state_reg <= CHECK;
                    CHECK: begin
                        if (pwr_good) begin
                            state_reg  <= RESTORE;
                            ret_en_reg <= 1'b0;
                        end
                    end
                    RESTORE: begin
                        state_reg  <= UNISO;
                        iso_en_reg <= 1'b0;
                    end
                    UNISO: begin
                        state_reg   <= ON;
                        pwr_ack_reg <= 1'b1;
                        busy_reg    <= 1'b0;
                    end
                    ON: begin
                        if (!pwr_req || !pwr_good) begin
                            state_reg   <= ISO;
                            pwr_ack_reg <= 1'b0;
                            iso_en_reg  <= 1'b1;
                            busy_reg    <= 1'b1;
                        end
                    end
                    ISO: begin
                        state_reg  <= SAVE;
                        ret_en_reg <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sw_en   = sw_en_reg;
    assign seg_cnt = seg_cnt_reg;
    assign iso_en  = iso_en_reg;
    assign ret_en  = ret_en_reg;
    assign pwr_ack = pwr_ack_reg;
    assign busy    = busy_reg;
    assign fault   = fault_reg;

endmodule

// File: tb/tb_scs8hd_lpflow_pwrsw_seq.sv
// Bench for the power-switch sequencer. Two configurations share one
// stimulus stream: the default one and a single-segment, single-cycle-step
// one. A phase-level reference model predicts every cycle's outputs; the
// predictions go into a queue and a separate monitor compares them.
module tb_scs8hd_lpflow_pwrsw_seq;

    localparam int A_NSEG = 4, A_STEP = 8, A_SET = 16, A_TMO = 256;
    localparam int B_NSEG = 1, B_STEP = 1, B_SET = 4,  B_TMO = 12;
    localparam int A_CW = $clog2(A_NSEG + 1);
    localparam int B_CW = $clog2(B_NSEG + 1);

    // Model phases: settle and power-good check are one waiting phase.
    localparam int P_OFF = 0, P_UP = 1, P_WAIT = 2, P_RES = 3, P_UNI = 4;
    localparam int P_ON = 5, P_ISO = 6, P_SAV = 7, P_DN = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pwr_req = 1'b0;
    logic pwr_good = 1'b1;
    logic fault_clr = 1'b0;

    logic [A_NSEG-1:0] a_sw_en;
    logic [A_CW-1:0]   a_seg_cnt;
    logic a_iso_en, a_ret_en, a_pwr_ack, a_busy, a_fault;
    logic [B_NSEG-1:0] b_sw_en;
    logic [B_CW-1:0]   b_seg_cnt;
    logic b_iso_en, b_ret_en, b_pwr_ack, b_busy, b_fault;

    always #5 clk = ~clk;

    scs8hd_lpflow_pwrsw_seq #(
        .NSEG(A_NSEG), .STEP_CYCLES(A_STEP), .SETTLE_CYCLES(A_SET), .TIMEOUT_CYCLES(A_TMO)
    ) dut_a (
        .clk(clk), .reset(reset), .pwr_req(pwr_req), .pwr_good(pwr_good),
        .fault_clr(fault_clr), .sw_en(a_sw_en), .iso_en(a_iso_en), .ret_en(a_ret_en),
        .pwr_ack(a_pwr_ack), .busy(a_busy), .fault(a_fault), .seg_cnt(a_seg_cnt)
    );

    scs8hd_lpflow_pwrsw_seq #(
        .NSEG(B_NSEG), .STEP_CYCLES(B_STEP), .SETTLE_CYCLES(B_SET), .TIMEOUT_CYCLES(B_TMO)
    ) dut_b (
        .clk(clk), .reset(reset), .pwr_req(pwr_req), .pwr_good(pwr_good),
        .fault_clr(fault_clr), .sw_en(b_sw_en), .iso_en(b_iso_en), .ret_en(b_ret_en),
        .pwr_ack(b_pwr_ack), .busy(b_busy), .fault(b_fault), .seg_cnt(b_seg_cnt)
    );

    logic [63:0] got_a, got_b;
    assign got_a = {52'd0, a_sw_en, a_seg_cnt, a_iso_en, a_ret_en, a_pwr_ack, a_busy, a_fault};
    assign got_b = {57'd0, b_sw_en, b_seg_cnt, b_iso_en, b_ret_en, b_pwr_ack, b_busy, b_fault};

    typedef struct {
        int ph;    // phase
        int seg;   // segments on
        int t;     // edges since the last segment step / direction change
        int e;     // edges since the ramp-up completed
        bit flt;   // sticky fault
    } mdl_t;

    typedef struct {
        int          cyc;
        logic [63:0] a;
        logic [63:0] b;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   done = 1'b0;
    int   req_cyc = 0;
    bit   lat_arm_a = 1'b0;
    bit   lat_arm_b = 1'b0;
    mdl_t ma, mb;

    function automatic mdl_t descend(mdl_t m);
        mdl_t n = m;
        n.seg = m.seg - 1;
        n.t   = 0;
        n.ph  = (n.seg == 0) ? P_OFF : P_DN;
        return n;
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit rst, bit req, bit good, bit clr,
                                   int nseg, int step, int settle, int tmo);
        mdl_t n = m;
        bit   set = 1'b0;
        if (rst) begin
            n.ph = P_OFF; n.seg = 0; n.t = 0; n.e = 0; n.flt = 1'b0;
            return n;
        end
        n.t = m.t + 1;
        n.e = m.e + 1;
        case (m.ph)
            P_OFF: if (req && !m.flt) begin n.ph = P_UP; n.seg = 1; n.t = 0; end
            P_UP: begin
                if (!req) n = descend(n);
                else if (n.t == step) begin
                    if (m.seg == nseg) begin n.ph = P_WAIT; n.e = 0; end
                    else begin n.seg = m.seg + 1; n.t = 0; end
                end
            end
            P_WAIT: begin
                if (n.e == tmo && !good) begin set = 1'b1; n = descend(n); end
                else if (!req) n = descend(n);
                else if (n.e > settle && good) n.ph = P_RES;
            end
            P_RES: n.ph = P_UNI;
            P_UNI: n.ph = P_ON;
            P_ON: if (!req || !good) begin set = !good; n.ph = P_ISO; end
            P_ISO: n.ph = P_SAV;
            P_SAV: n = descend(n);
            P_DN: begin
                if (req && !m.flt) begin n.ph = P_UP; n.seg = m.seg + 1; n.t = 0; end
                else if (n.t == step) n = descend(n);
            end
            default: n.ph = P_OFF;
        endcase
        n.flt = set ? 1'b1 : (clr ? 1'b0 : m.flt);
        return n;
    endfunction

    function automatic logic [63:0] mout(mdl_t m, int cw);
        logic [63:0] v;
        logic iso, ret, ack, bsy;
        iso = !(m.ph == P_UNI || m.ph == P_ON);
        ret = !(m.ph == P_RES || m.ph == P_UNI || m.ph == P_ON || m.ph == P_ISO);
        ack = (m.ph == P_ON);
        bsy = !(m.ph == P_OFF || m.ph == P_ON);
        v = (64'd1 << m.seg) - 64'd1;
        v = (v << cw) | 64'(m.seg);
        v = (v << 5) | {59'd0, iso, ret, ack, bsy, m.flt};
        return v;
    endfunction

    // Holds the given inputs for n cycles; fault_clr pulses on the first.
    task automatic cyc_run(input int n, input bit rq, input bit gd, input bit clr, input bit rst);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            pwr_req   = rq;
            pwr_good  = gd;
            fault_clr = clr && (i == 0);
            reset     = rst;
            @(posedge clk);
            ma = mstep(ma, rst, rq, gd, fault_clr, A_NSEG, A_STEP, A_SET, A_TMO);
            mb = mstep(mb, rst, rq, gd, fault_clr, B_NSEG, B_STEP, B_SET, B_TMO);
            e.cyc = cyc;
            e.a   = mout(ma, A_CW);
            e.b   = mout(mb, B_CW);
            sb.push_back(e);
            cyc++;
            #2;
        end
    endtask

    // Monitor: one scoreboard entry per cycle, compared on the falling edge.
    initial begin
        exp_t e;
        bit   pa;
        bit   pb;
        pa = 1'b0;
        pb = 1'b0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (sb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL scoreboard_empty cyc=%0d got=none expected=entry", cyc);
            end else begin
                e = sb.pop_front();
                n_checks++;
                if (got_a !== e.a) begin
                    n_fail++;
                    $display("FAIL cfgA_outputs cyc=%0d got=%h expected=%h", e.cyc, got_a, e.a);
                end
                n_checks++;
                if (got_b !== e.b) begin
                    n_fail++;
                    $display("FAIL cfgB_outputs cyc=%0d got=%h expected=%h", e.cyc, got_b, e.b);
                end
                if (lat_arm_a && a_pwr_ack && !pa) begin
                    lat_arm_a = 1'b0;
                    n_checks++;
                    if (e.cyc - req_cyc != A_NSEG * A_STEP + A_SET + 3) begin
                        n_fail++;
                        $display("FAIL cfgA_ack_latency got=%0d expected=%0d",
                                 e.cyc - req_cyc, A_NSEG * A_STEP + A_SET + 3);
                    end
                end
                if (lat_arm_b && b_pwr_ack && !pb) begin
                    lat_arm_b = 1'b0;
                    n_checks++;
                    if (e.cyc - req_cyc != B_NSEG * B_STEP + B_SET + 3) begin
                        n_fail++;
                        $display("FAIL cfgB_ack_latency got=%0d expected=%0d",
                                 e.cyc - req_cyc, B_NSEG * B_STEP + B_SET + 3);
                    end
                end
            end
            pa = a_pwr_ack;
            pb = b_pwr_ack;
        end
    end

    // Stimulus
    initial begin
        int n;
        bit rq, gd, clr, rst;
        ma = '{ph: P_OFF, seg: 0, t: 0, e: 0, flt: 1'b0};
        mb = '{ph: P_OFF, seg: 0, t: 0, e: 0, flt: 1'b0};

        cyc_run(3, 1'b0, 1'b1, 1'b0, 1'b1);      // reset state
        req_cyc = cyc;
        lat_arm_a = 1'b1;
        lat_arm_b = 1'b1;
        cyc_run(60, 1'b1, 1'b1, 1'b0, 1'b0);     // full power-up
        @(negedge clk);
        #1;
        n_checks++;
        if (lat_arm_a || lat_arm_b) begin
            n_fail++;
            $display("FAIL ack_seen got=%0b%0b expected=00 (pending flags A,B)", lat_arm_a, lat_arm_b);
        end
        cyc_run(40, 1'b0, 1'b1, 1'b0, 1'b0);     // power-down
        cyc_run(10, 1'b1, 1'b1, 1'b0, 1'b0);     // abort at seg_cnt=2
        cyc_run(20, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc_run(340, 1'b1, 1'b0, 1'b0, 1'b0);    // timeout, then request ignored
        cyc_run(70, 1'b1, 1'b1, 1'b1, 1'b0);     // clear and retry
        cyc_run(5, 1'b1, 1'b0, 1'b0, 1'b0);      // pwr_good lost while on
        cyc_run(40, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc_run(2, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc_run(20, 1'b1, 1'b1, 1'b0, 1'b0);     // into ramp-up
        cyc_run(1, 1'b1, 1'b1, 1'b0, 1'b1);      // reset mid ramp
        cyc_run(5, 1'b0, 1'b1, 1'b0, 1'b0);

        for (int k = 0; k < 150; k++) begin
            n   = $urandom_range(1, 40);
            rq  = ($urandom_range(0, 3) != 0);
            gd  = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 39) == 0);
            if (rst) n = 1;
            cyc_run(n, rq, gd, clr, rst);
        end

        @(negedge clk);
        #1;
        done = 1'b1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drained got=%0d expected=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
